// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: FSM encodings, word geometry,
// error encoding and the address-check helper.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int OFFS_W = 2;
    localparam int CNT_W  = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic ERR_NONE   = 1'b0;
    localparam logic ERR_ACCESS = 1'b1;

    // Misaligned or beyond-the-array word addresses are flagged, never indexed.
    function automatic logic addr_error(input logic [WORD_W-1:0]        addr,
                                        input logic [WORD_W-OFFS_W-1:0] depth);
        logic err_s;
        if (addr[OFFS_W-1:0] != {OFFS_W{1'b0}}) begin
            err_s = ERR_ACCESS;
        end else if (addr[WORD_W-1:OFFS_W] >= depth) begin
            err_s = ERR_ACCESS;
        end else begin
            err_s = ERR_NONE;
        end
        return err_s;
    endfunction

endpackage

// File: rtl/dmem_wait_counter.sv
// Down-counter for the responder's wait states: load, decrement to zero, report done.
module dmem_wait_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [CNT_W-1:0] count_r;

    // Count register: load wins over decrement, and the count never wraps below zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != {CNT_W{1'b0}})) begin
            count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: one request at a time, programmable wait states,
// register-based word array, one-cycle response with access-error flag.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : {CNT_W{1'b0}};
    localparam logic [WORD_W-OFFS_W-1:0] DEPTH_L = (WORD_W-OFFS_W)'(DEPTH_WORDS);

    logic [1:0]        state_r;
    logic [1:0]        state_next_s;
    logic              req_ready_r;
    logic              resp_valid_r;
    logic              lat_write_r;
    logic [WORD_W-1:0] lat_addr_r;
    logic [WORD_W-1:0] lat_wdata_r;
    logic [WORD_W-1:0] mem_r [DEPTH_WORDS];

    logic              accept_s;
    logic              cnt_load_s;
    logic              cnt_dec_s;
    logic              cnt_done_s;
    logic              addr_err_s;
    logic [IDX_W-1:0]  idx_s;

    assign accept_s   = (state_r == ST_IDLE) && req_valid && req_ready_r;
    assign cnt_dec_s  = (state_r == ST_WAIT);
    assign addr_err_s = addr_error(lat_addr_r, DEPTH_L);
    assign idx_s      = lat_addr_r[IDX_W+OFFS_W-1:OFFS_W];

    dmem_wait_counter #(
        .CNT_W (CNT_W)
    ) u_wait_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load_s),
        .load_val (WAIT_LOAD),
        .dec      (cnt_dec_s),
        .done     (cnt_done_s)
    );

    // Handshake FSM next-state decode; the counter is loaded on acceptance.
    always_comb begin
        state_next_s = state_r;
        cnt_load_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    cnt_load_s = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_next_s = ST_WAIT;
                    end else begin
                        state_next_s = ST_RESP;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_done_s) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_RESP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State, registered handshake outputs and the latched request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            lat_write_r  <= 1'b0;
            lat_addr_r   <= {WORD_W{1'b0}};
            lat_wdata_r  <= {WORD_W{1'b0}};
        end else begin
            state_r      <= state_next_s;
            req_ready_r  <= (state_next_s == ST_IDLE);
            resp_valid_r <= (state_next_s == ST_RESP);
            if (accept_s) begin
                lat_write_r <= req_write;
                lat_addr_r  <= req_addr;
                lat_wdata_r <= req_wdata;
            end
        end
    end

    // Word array: a good store commits on the edge that leaves RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_r[i] <= {WORD_W{1'b0}};
            end
        end else if ((state_r == ST_RESP) && lat_write_r && (addr_err_s == ERR_NONE)) begin
            mem_r[idx_s] <= lat_wdata_r;
        end
    end

    // Response data/error decode; zero outside the response cycle, for stores and on error.
    always_comb begin
        resp_rdata = {WORD_W{1'b0}};
        resp_err   = ERR_NONE;
        if (resp_valid_r) begin
            resp_err = addr_err_s;
            if ((addr_err_s == ERR_NONE) && !lat_write_r) begin
                resp_rdata = mem_r[idx_s];
            end else begin
                resp_rdata = {WORD_W{1'b0}};
            end
        end else begin
            resp_rdata = {WORD_W{1'b0}};
            resp_err   = ERR_NONE;
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance share stimulus.
module tb_dmem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;

    logic        ready2, valid2, err2;
    logic [31:0] rdata2;
    logic        ready0, valid0, err0;
    logic [31:0] rdata0;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    exp_t        q2[$];
    exp_t        q0[$];
    logic [31:0] model [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready2),
        .resp_valid(valid2), .resp_rdata(rdata2), .resp_err(err2));

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready0),
        .resp_valid(valid0), .resp_rdata(rdata0), .resp_err(err0));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Response monitors: every pulse must match the oldest expectation, including its edge.
    always @(negedge clk) begin : mon2
        exp_t e;
        if (valid2 === 1'b1) begin
            chk("w2_unexpected_resp", 32'(q2.size() > 0), 32'd1);
            if (q2.size() > 0) begin
                e = q2.pop_front();
                chk("w2_rdata", rdata2, e.rdata);
                chk("w2_err", {31'd0, err2}, {31'd0, e.err});
                chk("w2_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    always @(negedge clk) begin : mon0
        exp_t e;
        if (valid0 === 1'b1) begin
            chk("w0_unexpected_resp", 32'(q0.size() > 0), 32'd1);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("w0_rdata", rdata0, e.rdata);
                chk("w0_err", {31'd0, err0}, {31'd0, e.err});
                chk("w0_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    function automatic exp_t predict(input logic wr, input logic [31:0] addr,
                                     input logic [31:0] data, input int due);
        exp_t e;
        e.err   = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd256);
        e.rdata = (!wr && !e.err) ? model[addr[9:2]] : 32'h0;
        e.due   = due;
        if (wr && !e.err) model[addr[9:2]] = data;
        return e;
    endfunction

    task automatic drain();
        for (int k = 0; k < 20; k++) begin
            if (q2.size() == 0 && q0.size() == 0) break;
            @(negedge clk);
            #1;
        end
        chk("drain_timeout", 32'(q2.size() + q0.size()), 32'd0);
        q2.delete();
        q0.delete();
    endtask

    // One request into both instances; acceptance edge T gives responses on edges T+2 and T.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        @(negedge clk);
        chk("w2_ready_idle", {31'd0, ready2}, 32'd1);
        chk("w0_ready_idle", {31'd0, ready0}, 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        @(posedge clk);
        #1;
        e = predict(wr, addr, data, cyc + 2);
        q2.push_back(e);
        e.due = cyc;
        q0.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h0BAD_0BAD;
        drain();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        for (int i = 0; i < 256; i++) model[i] = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Idle after reset: ready, no response, quiet data.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_ready", {31'd0, ready2}, 32'd1);
            chk("rst_valid", {31'd0, valid2}, 32'd0);
            chk("rst_rdata", rdata2, 32'h0);
            chk("rst_err", {31'd0, err2}, 32'd0);
            chk("rst_valid_w0", {31'd0, valid0}, 32'd0);
        end

        issue(1'b0, 32'h0000_0040, 32'h0);
        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        issue(1'b0, 32'h0000_0010, 32'h0);
        issue(1'b1, 32'h0000_0013, 32'h5555_5555);
        issue(1'b0, 32'h0000_0010, 32'h0);
        issue(1'b0, 32'h0000_0400, 32'h0);
        issue(1'b1, 32'h0000_0400, 32'h7777_7777);
        issue(1'b1, 32'h0000_03FC, 32'hCAFE_F00D);
        issue(1'b0, 32'h0000_03FC, 32'h0);
        issue(1'b0, 32'h0000_0000, 32'h0);

        for (int i = 0; i < 12; i++) issue(1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));

        // req_valid held high with a new address every cycle.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("w2_stream_ready", {31'd0, ready2}, 32'((i % 4) == 0));
            chk("w0_stream_ready", {31'd0, ready0}, 32'((i % 2) == 0));
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = 32'h100 + 32'(4 * i);
            @(posedge clk);
            #1;
            if ((i % 4) == 0) q2.push_back(predict(1'b0, 32'h100 + 32'(4 * i), 32'h0, cyc + 2));
            if ((i % 2) == 0) q0.push_back(predict(1'b0, 32'h100 + 32'(4 * i), 32'h0, cyc));
        end
        @(negedge clk);
        req_valid = 1'b0;
        drain();

        // Reset during the WAIT of a store: the slow instance must never respond.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0020;
        req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        e = predict(1'b1, 32'h0000_0020, 32'h1234_5678, cyc);
        q0.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 256; i++) model[i] = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_mid_no_resp", {31'd0, valid2}, 32'd0);
        end
        chk("rst_mid_w0_pending", 32'(q0.size()), 32'd0);
        q0.delete();
        issue(1'b0, 32'h0000_0020, 32'h0);
        issue(1'b0, 32'h0000_0010, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
